register_file: RTL and testbench
================================

Name: register_file

Overview:
- Integer register file on the consumer side of the instruction decoder's rs1/rs2/rd address fields.
- Provides two read ports and one write-back port.
- Reads use a valid/ready request and a registered response, so the storage can map to block RAM.
- After reset, an init sequencer clears every entry before the first request is accepted.

Parameters:
XLEN, 32, data width of each register
REG_FILE_DEPTH, 32, number of registers
REG_FILE_ADDR_LEN, $clog2(REG_FILE_DEPTH), width of the register addresses

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
rd_req_valid  input  1  read request valid
rd_req_ready  output  1  read request can be accepted
rs1  input  REG_FILE_ADDR_LEN  read address 1
rs2  input  REG_FILE_ADDR_LEN  read address 2
rd_rsp_valid  output  1  read response valid, one-cycle pulse
rs1_data  output  XLEN  data for the captured rs1
rs2_data  output  XLEN  data for the captured rs2
wr_en  input  1  write-back enable
rd  input  REG_FILE_ADDR_LEN  write address
rd_data  input  XLEN  write data
busy  output  1  init sweep in progress

Behaviour:
- Reset (async assert, sync release): state=INIT, init counter=0, rd_req_ready=0, rd_rsp_valid=0, rs1_data=0, rs2_data=0, busy=1.
  - The storage array itself has no reset; it is cleared by the sweep.
- States: INIT, RUN.
- INIT:
  - Each cycle writes 0 to entry [counter], then counter increments.
  - On the cycle the counter reaches REG_FILE_DEPTH-1, that entry is written and the next state is RUN.
  - The sweep takes exactly REG_FILE_DEPTH cycles after reset release.
  - wr_en is ignored and rd_req_ready=0.
- RUN:
  - rd_req_ready=1 and busy=0, held until the next reset.
  - There is no other transition out of RUN.
- Read accept = rd_req_valid & rd_req_ready.
  - rs1/rs2 are sampled at the accepting edge.
  - On the following cycle rd_rsp_valid=1 with the data (latency 1).
  - Back-to-back accepts give back-to-back response pulses; throughput is 1 request per cycle.
  - There is no response backpressure. A consumer that is not ready must not issue the request.
- Without an accept, rd_rsp_valid=0 and rs1_data/rs2_data hold their last values.
- Address 0:
  - Always reads 0.
  - A write with rd=0 is dropped, so entry 0 is never written in RUN.
- Write: in RUN, when wr_en=1 and rd!=0, mem[rd] <= rd_data at the edge. The write is visible to any read accepted on a later cycle.
- Same-edge write and read accept to the same nonzero address: the response data is defined by REGFILE_WR_BYPASS_EN (see below).
- rs1==rs2 is legal; both outputs carry the same value.
- Data is captured at accept. A write between the accept and the response does not alter the pending response.
- Out-of-range addresses (REG_FILE_DEPTH not a power of 2):
  - Reads return 0.
  - Writes are dropped.
- Reset mid-operation (INIT or RUN):
  - Any pending response is cancelled.
  - The sweep restarts from counter 0.
  - All registers read 0 once RUN is re-entered.

Optional Feature:
Macro REGFILE_WR_BYPASS_EN.
- Defined: a read accepted on the same edge as a write with rd==rsN (rd!=0) returns rd_data on that port's response (write-to-read forwarding). Each port is handled independently.
- Undefined: that response returns the pre-write register contents. The new value is visible from the next accepted read.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset release, rd_req_valid held 1 -> rd_req_ready=0 and busy=1 for exactly 32 cycles; the first accept occurs on cycle 32; reading rs1=5, rs2=31 returns 0, 0.
2. In RUN, write x3=0xDEADBEEF; next cycle read rs1=3, rs2=0 -> one cycle later rd_rsp_valid=1, rs1_data=0xDEADBEEF, rs2_data=0.
3. Write rd=0, rd_data=0x12345678, then read rs1=0 -> rs1_data=0.
4. Same edge: write x7=0xA5A5A5A5 (x7 previously 0x1) and accept a read with rs1=7, rs2=7 -> both outputs 0xA5A5A5A5 with REGFILE_WR_BYPASS_EN defined, 0x00000001 without; a following read gives 0xA5A5A5A5 in both builds.
5. Three back-to-back accepts (rs1=1,2,3 holding 0x11,0x22,0x33) -> three consecutive rd_rsp_valid pulses with 0x11, 0x22, 0x33; rd_rsp_valid=0 on the cycle after the last.
6. Assert rst mid-stream, the cycle after an accept and with x9=0x99 -> rd_rsp_valid=0 immediately; after release, a 32-cycle INIT, then reading x9 returns 0.

Source files
------------

// File: rtl/register_file.sv
// Two-read, one-write integer register file with a registered read response and a
// post-reset clearing sweep. Define REGFILE_WR_BYPASS_EN for same-edge write-to-read forwarding.
module register_file #(
    parameter int XLEN              = 32,
    parameter int REG_FILE_DEPTH    = 32,
    parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_req_valid,
    output logic                         rd_req_ready,
    input  logic [REG_FILE_ADDR_LEN-1:0] rs1,
    input  logic [REG_FILE_ADDR_LEN-1:0] rs2,
    output logic                         rd_rsp_valid,
    output logic [XLEN-1:0]              rs1_data,
    output logic [XLEN-1:0]              rs2_data,
    input  logic                         wr_en,
    input  logic [REG_FILE_ADDR_LEN-1:0] rd,
    input  logic [XLEN-1:0]              rd_data,
    output logic                         busy
);

    localparam logic [0:0] INIT = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    localparam logic [REG_FILE_ADDR_LEN-1:0] LAST = REG_FILE_ADDR_LEN'(REG_FILE_DEPTH - 1);

    logic [0:0]                   state;
    logic [REG_FILE_ADDR_LEN-1:0] init_cnt;
    logic [XLEN-1:0]              mem [REG_FILE_DEPTH];
    logic                         accept;
    logic                         write_ok;
    logic [XLEN-1:0]              rs1_val;
    logic [XLEN-1:0]              rs2_val;

    function automatic logic in_range(input logic [REG_FILE_ADDR_LEN-1:0] a);
        return 32'(a) < REG_FILE_DEPTH;
    endfunction

    assign rd_req_ready = (state == RUN);
    assign busy         = (state == INIT);
    assign accept       = rd_req_valid & rd_req_ready;
    assign write_ok     = (state == RUN) && wr_en && (rd != '0) && in_range(rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else if (state == INIT) begin
            if (init_cnt == LAST) state <= RUN;
            else init_cnt <= init_cnt + REG_FILE_ADDR_LEN'(1);
        end
    end

    // Storage has no reset so it can map onto block RAM; the sweep owns the write port in INIT.
    always_ff @(posedge clk) begin
        if (state == INIT) mem[init_cnt] <= '0;
        else if (write_ok) mem[rd] <= rd_data;
    end

    always_comb begin
        rs1_val = (rs1 != '0 && in_range(rs1)) ? mem[rs1] : '0;
        rs2_val = (rs2 != '0 && in_range(rs2)) ? mem[rs2] : '0;
`ifdef REGFILE_WR_BYPASS_EN
        if (write_ok && rd == rs1) rs1_val = rd_data;
        if (write_ok && rd == rs2) rs2_val = rd_data;
`endif
    end

    // Response data is latched at accept and held until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_rsp_valid <= 1'b0;
            rs1_data     <= '0;
            rs2_data     <= '0;
        end else begin
            rd_rsp_valid <= accept;
            if (accept) begin
                rs1_data <= rs1_val;
                rs2_data <= rs2_val;
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized plus directed bench for register_file, checked every cycle against an
// array-based model of the register file contents and response timing.
module tb_register_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req_valid = 1'b0;
    logic        rd_req_ready;
    logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
    logic        rd_rsp_valid;
    logic [31:0] rs1_data, rs2_data;
    logic        wr_en = 1'b0;
    logic [31:0] rd_data = '0;
    logic        busy;

`ifdef REGFILE_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    bit done   = 1'b0;

    register_file dut (
        .clk(clk), .rst(rst), .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
        .rs1(rs1), .rs2(rs2), .rd_rsp_valid(rd_rsp_valid), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .wr_en(wr_en), .rd(rd), .rd_data(rd_data), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: registers as a plain array; all zero after a reset once 32 cycles have passed.
    logic [31:0] m [32];
    int          since_rst = 0;
    logic        ev = 1'b0;
    logic [31:0] e1 = '0, e2 = '0;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (BYP && wr_en && rd == a) return rd_data;
        return m[a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            since_rst = 0;
            ev = 1'b0; e1 = '0; e2 = '0;
            for (int i = 0; i < 32; i++) m[i] = '0;
        end else if (since_rst < 32) begin
            since_rst++;
            ev = 1'b0;
        end else begin
            ev = rd_req_valid;
            if (rd_req_valid) begin
                e1 = model_read(rs1);
                e2 = model_read(rs2);
            end
            if (wr_en && rd != 0) m[rd] = rd_data;
        end
    end

    always begin
        @(posedge clk);
        #2;
        if (!done) begin
            chk("ready", {31'b0, rd_req_ready}, {31'b0, (!rst && since_rst >= 32)});
            chk("busy", {31'b0, busy}, {31'b0, !(!rst && since_rst >= 32)});
            chk("rsp_valid", {31'b0, rd_rsp_valid}, {31'b0, ev});
            chk("rs1_data", rs1_data, e1);
            chk("rs2_data", rs2_data, e2);
        end
    end

    task automatic cyc(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        rd_req_valid = v; rs1 = a1; rs2 = a2;
        wr_en = we; rd = wa; rd_data = wd;
    endtask

    task automatic rsp(input string name, input logic [31:0] x1, input logic [31:0] x2);
        @(posedge clk);
        #1;
        chk({name, "_vld"}, {31'b0, rd_rsp_valid}, 32'd1);
        chk({name, "_rs1"}, rs1_data, x1);
        chk({name, "_rs2"}, rs2_data, x2);
    endtask

    // Called at a negedge right after reset release; counts cycles until ready.
    task automatic wait_ready(input string name);
        int n = 0;
        while (!rd_req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, 32);
    endtask

    initial begin
        // 1: reset state, sweep length, INIT ignores writes
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'b0, rd_req_ready}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd1);
        chk("rst_vld", {31'b0, rd_rsp_valid}, 32'd0);
        chk("rst_rs1", rs1_data, 32'd0);
        rst = 1'b0;
        rd_req_valid = 1'b1; rs1 = 5; rs2 = 31;
        wr_en = 1'b1; rd = 5; rd_data = 32'hFFFF_FFFF;
        wait_ready("init_len");
        wr_en = 1'b0;
        rsp("t1", 32'h0, 32'h0);
        cyc(0, 0, 0, 0, 0, 0);

        // 2: write then read, x0 reads zero
        cyc(0, 0, 0, 1, 3, 32'hDEAD_BEEF);
        cyc(1, 3, 0, 0, 0, 0);
        rsp("t2", 32'hDEAD_BEEF, 32'h0);

        // 3: write to x0 dropped
        cyc(0, 0, 0, 1, 0, 32'h1234_5678);
        cyc(1, 0, 0, 0, 0, 0);
        rsp("t3", 32'h0, 32'h0);

        // 4: same-edge write and read
        cyc(0, 0, 0, 1, 7, 32'h1);
        cyc(1, 7, 7, 1, 7, 32'hA5A5_A5A5);
        rsp("t4a", BYP ? 32'hA5A5_A5A5 : 32'h1, BYP ? 32'hA5A5_A5A5 : 32'h1);
        cyc(1, 7, 7, 0, 0, 0);
        rsp("t4b", 32'hA5A5_A5A5, 32'hA5A5_A5A5);

        // 5: back-to-back reads
        cyc(0, 0, 0, 1, 1, 32'h11);
        cyc(0, 0, 0, 1, 2, 32'h22);
        cyc(0, 0, 0, 1, 3, 32'h33);
        cyc(1, 1, 3, 0, 0, 0);
        rsp("t5a", 32'h11, 32'h33);
        cyc(1, 2, 2, 0, 0, 0);
        rsp("t5b", 32'h22, 32'h22);
        cyc(1, 3, 1, 0, 0, 0);
        rsp("t5c", 32'h33, 32'h11);
        cyc(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("t5_end_vld", {31'b0, rd_rsp_valid}, 32'd0);

        // 6: reset with a response in flight
        cyc(0, 0, 0, 1, 9, 32'h99);
        cyc(1, 9, 0, 0, 0, 0);
        rsp("t6a", 32'h99, 32'h0);
        @(negedge clk);
        rd_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_rst_vld", {31'b0, rd_rsp_valid}, 32'd0);
        chk("t6_rst_busy", {31'b0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_ready("reinit_len");
        rd_req_valid = 1'b1; rs1 = 9; rs2 = 9;
        rsp("t6b", 32'h0, 32'h0);

        // Random traffic; small address window forces same-edge collisions.
        for (int i = 0; i < 2000; i++) begin
            logic [4:0] a1, a2, wa;
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            wa = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            cyc(1'($urandom), a1, a2, 1'($urandom), wa, $urandom);
        end
        cyc(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
